// File: rtl/sum8_accum_ctrl.sv
// sum8_accum_ctrl
// Drives an external 8-bit add/sub unit (start/sel/src1/src2 -> result/done)
// from a valid/ready stream of signed-op beats. It keeps a running 8-bit
// accumulator over a frame and presents the total, the beat count and an
// abort flag on the frame's last beat, or when the add/sub unit times out.
module sum8_accum_ctrl #(
   parameter int TIMEOUT = 15,   // max WAIT cycles for add_done before abort (>= 1)
   parameter int CNT_W   = 8     // width of the beat counter
) (
   input  logic             clk,
   input  logic             n_rst,
   // command stream
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sel,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   // frame result stream
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_err,
   // add/sub unit interface
   output logic             add_start,
   output logic             add_sel,
   output logic [7:0]       add_src1,
   output logic [7:0]       add_src2,
   input  logic [7:0]       add_result,
   input  logic             add_done
);

   // The timeout counter only has to reach TIMEOUT-1, so clog2(TIMEOUT)
   // bits are enough; keep at least one bit for TIMEOUT == 1.
   localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // waiting for a beat
      ISSUE = 2'd1,   // one-cycle start pulse to the add/sub unit
      WAIT  = 2'd2,   // waiting for add_done or timeout
      OUT   = 2'd3    // presenting the frame result
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        acc_q,   acc_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_q,   err_d;
   logic              sel_q,   sel_d;
   logic [7:0]        data_q,  data_d;
   logic              last_q,  last_d;
   logic [TMO_W-1:0]  tmo_q,   tmo_d;

   // State and datapath registers; asynchronous reset drops any partial frame.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         sel_q   <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         err_q   <= err_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state and datapath updates; every register holds unless a state acts on it.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      err_d   = err_q;
      sel_d   = sel_q;
      data_d  = data_q;
      last_d  = last_q;
      tmo_d   = tmo_q;

      unique case (state_q)
         IDLE: begin
            // Beat operands are captured here so the add/sub inputs stay
            // stable through ISSUE and WAIT regardless of the stream.
            if (in_valid) begin
               sel_d   = in_sel;
               data_d  = in_data;
               last_d  = in_last;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT;
         end

         WAIT: begin
            if (add_done) begin
               acc_d   = add_result;
               count_d = count_q + CNT_ONE;
               state_d = last_q ? OUT : IDLE;
            end else if (tmo_q == TMO_LAST) begin
               // Abort: accumulator and count keep their pre-beat values.
               err_d   = 1'b1;
               state_d = OUT;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
            end
         end

         OUT: begin
            // Result stays on the outputs until the consumer takes it;
            // the next frame then starts from a clean accumulator.
            if (out_ready) begin
               acc_d   = '0;
               count_d = '0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and add/sub interface outputs decode directly from registers.
   assign in_ready  = (state_q == IDLE);
   assign add_start = (state_q == ISSUE);
   assign add_sel   = sel_q;
   assign add_src1  = acc_q;
   assign add_src2  = data_q;

   assign out_valid = (state_q == OUT);
   assign out_acc   = acc_q;
   assign out_count = count_q;
   assign out_err   = err_q;

endmodule
